uart_rx: RTL
============

# uart_rx

Serial receiver for the SoC's UART: recovers 8N1 frames from the `rx` pin and presents each byte on a valid/ready stream toward the memory-mapped peripheral space. It is the receive counterpart of the UART transmitter inside `DataMemory`, and uses the same `CLKS_PER_BIT` baud convention (868 at 100 MHz / 115200). An optional receive FIFO absorbs bursts while software polls.

## Interface

- `CLKS_PER_BIT`, 868, clock cycles per serial bit; integer ≥ 4.
- `FIFO_DEPTH`, 8, receive FIFO entries; power of two ≥ 2; used only with `UART_RX_FIFO_EN`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input, asynchronous to `clk`, idles high.
- `rx_data`  out  8  received byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts byte.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: completed byte dropped, no storage.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation

- `rx` passes through a 2-flop synchronizer; both flops reset to 1. The FSM sees only the synchronized value `rx_s`.
- FSM states:
  - IDLE: when `rx_s`=0, go to START and clear the bit counter.
  - START: count to `CLKS_PER_BIT/2-1` (integer division), then check `rx_s`. If 0, go to DATA with the counter cleared. If 1, treat as a glitch and return to IDLE.
  - DATA: sample `rx_s` when the counter reaches `CLKS_PER_BIT-1`, then clear the counter. Bits are shifted in LSB first. After 8 bits, go to STOP.
  - STOP: sample at `CLKS_PER_BIT-1`.
    - If 1: push the byte and go to IDLE. IDLE is entered mid stop bit, which allows resync on back-to-back frames.
    - If 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being read as a start bit.
- Bit counter width: `$clog2(CLKS_PER_BIT)`. The counter never wraps past `CLKS_PER_BIT-1`.
- Output handshake:
  - A transfer occurs on a rising edge with `rx_valid`=1 and `rx_ready`=1.
  - `rx_data` is held stable while `rx_valid`=1 and `rx_ready`=0.
  - `rx_ready` may be high while `rx_valid` is low.
- Storage without FIFO: a single holding register.
  - Push into an empty register sets `rx_valid`.
  - Push while full with a same-cycle pop: the new byte loads and `rx_valid` stays 1.
  - Push while full with no pop: the new byte is dropped, `overrun_err` pulses, and the held byte is unchanged.
- Storage with FIFO: see Configuration.
- `busy` is 1 in START, DATA, STOP and WAIT_HIGH.

## Timing

- Reset values (asynchronous):
  - `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun_err`=0, `busy`=0.
  - FSM in IDLE, counters cleared, storage empty.
- Reset mid-frame aborts the frame; no partial byte is ever presented.
- Synchronizer latency: 2 cycles.
- `rx_valid` first rises exactly 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 clock edges after the first edge that samples `rx` low. For `CLKS_PER_BIT`=16 this is 155.
- `frame_err` and `overrun_err` assert on the edge after the stop-bit sample and last exactly one cycle.
- A pop deasserts `rx_valid` on the next edge if storage becomes empty.

## Configuration

- `UART_RX_FIFO_EN` defined: storage is a `FIFO_DEPTH`-entry circular FIFO.
  - First-word fall-through: `rx_data` is the head entry.
  - Push is allowed when not full, or when full with a same-cycle pop.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push while full with no pop sets `overrun_err`.
- `UART_RX_FIFO_EN` undefined: single holding register as described under Operation; `FIFO_DEPTH` is ignored.

## Test plan

All scenarios use `CLKS_PER_BIT`=16.

- 0xA5 framed 8N1, `rx_ready`=1 → `rx_data`=0xA5 and `rx_valid` high for 1 cycle, exactly 155 cycles after start edge. No error pulses.
- `rx` low for 4 cycles, then high → `busy` pulses, no `rx_valid`, no `frame_err`, FSM back in IDLE.
- 0x3C with stop bit held low for 2 bit times, then 0x55 normally → `frame_err` single pulse, 0x3C never presented, 0x55 received.
- `rx_ready`=0, send 0x11 then 0x22:
  - Without FIFO → `rx_data` stays 0x11; `overrun_err` pulses once at the 0x22 stop sample.
  - With FIFO (depth 8), send bytes 0x01..0x09 → 0x01..0x08 popped in order; `overrun_err` pulses on 0x09.
- `rst_n` low during data bit 3 of 0xC3 → all outputs reset immediately. After release, 0x7E is received correctly with no stale bits.
- 0x00 then 0xFF back-to-back with no idle gap → both bytes received in order, no errors.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output; optional FIFO via UART_RX_FIFO_EN
module uart_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
   } state_t;

   logic          rx_meta_q, rx_s_q;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          push_q, push_d;
   logic          ferr_pend_q, ferr_pend_d;
   logic          frame_err_q, overrun_q;

   // two-flop synchronizer, idles high so reset does not look like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // FSM and datapath registers; push/frame-error are staged one cycle before storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         push_q      <= 1'b0;
         ferr_pend_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         push_q      <= push_d;
         ferr_pend_q <= ferr_pend_d;
         frame_err_q <= ferr_pend_q;
      end
   end

   // next-state logic: mid-bit sampling after a half-bit start qualification
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      push_d      = 1'b0;
      ferr_pend_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == LAST_CNT) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  push_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_pend_d = 1'b1;
                  state_d     = S_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT_HIGH: begin
            if (rx_s_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign frame_err = frame_err_q;

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   count_q;
   logic          full, pop, push_ok;

   assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
   assign pop     = (count_q != '0) && rx_ready;
   assign push_ok = push_q && (!full || pop);

   // circular FIFO, first-word fall-through; pointers wrap naturally at power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= shift_q;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         if (push_ok && !pop)      count_q <= count_q + 1'b1;
         else if (!push_ok && pop) count_q <= count_q - 1'b1;
         overrun_q <= push_q && !push_ok;
      end
   end

   assign rx_data  = mem_q[rd_q];
   assign rx_valid = (count_q != '0);
`else
   logic [7:0] hold_q;
   logic       valid_q, pop, load;

   assign pop  = valid_q && rx_ready;
   assign load = push_q && (!valid_q || pop);

   // single holding register; a byte arriving while full and unpopped is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (load) hold_q <= shift_q;
         valid_q   <= load || (valid_q && !pop);
         overrun_q <= push_q && !load;
      end
   end

   assign rx_data  = hold_q;
   assign rx_valid = valid_q;
`endif

   assign overrun_err = overrun_q;

endmodule
